// File: rtl/binary_adder_subtractor.sv
// binary_adder_subtractor: registered ripple-carry adder/subtractor with a one-cycle result.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; clears s, cout (and ovf)
//   a    - operand A, WIDTH bits
//   b    - operand B, WIDTH bits; inverted when en=1
//   cin  - carry into bit 0; drive equal to en for a true subtract
//   en   - 0 = add, 1 = subtract
//   s    - registered sum/difference
//   cout - registered carry out of the MSB (in subtract mode, 1 = no borrow)
//   ovf  - registered signed overflow, present only when ADDSUB_OVERFLOW_EN is defined
module binary_adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADDSUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH:0]   c;
    assign bx   = b ^ {WIDTH{en}};
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s_n[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= s_n;
            cout <= c[WIDTH];
        end
    end
`ifdef ADDSUB_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) ovf <= 1'b0;
        else     ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_binary_adder_subtractor.sv
// tb_binary_adder_subtractor: directed and random checks of binary_adder_subtractor against an arithmetic model.
// Ports: none (top-level bench); drives clk, rst, a, b, cin, en and observes s, cout (and ovf with ADDSUB_OVERFLOW_EN).
module tb_binary_adder_subtractor;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    int           checks = 0;
    int           errors = 0;
`ifdef ADDSUB_OVERFLOW_EN
    logic         ovf;
`endif

    binary_adder_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .en  (en),
        .s   (s),
        .cout(cout)
`ifdef ADDSUB_OVERFLOW_EN
        ,
        .ovf (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Unsigned reference: a + (b or its ones' complement) + cin, kept to WIDTH+1 bits.
    function automatic logic [W:0] model_sum(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                             input logic tc, input logic te);
        int bv;
        int r;
        bv = te ? (1 << W) - 1 - int'(tb_v) : int'(tb_v);
        r  = int'(ta) + bv + int'(tc);
        return r[W:0];
    endfunction

    // Signed reference: true two's-complement result falls outside the W-bit range.
    function automatic logic model_ovf(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                       input logic tc, input logic te);
        int sa;
        int sb;
        int r;
        sa = int'(ta) >= (1 << (W - 1)) ? int'(ta) - (1 << W) : int'(ta);
        sb = int'(tb_v) >= (1 << (W - 1)) ? int'(tb_v) - (1 << W) : int'(tb_v);
        if (te) sb = -sb - 1;
        r = sa + sb + int'(tc);
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    task automatic check(input string tag, input logic [W:0] exp_cs, input logic exp_ovf);
        checks++;
        assert ({cout, s} === exp_cs)
        else begin
            errors++;
            $error("FAIL %s: {cout,s} got %b expected %b", tag, {cout, s}, exp_cs);
        end
`ifdef ADDSUB_OVERFLOW_EN
        checks++;
        assert (ovf === exp_ovf)
        else begin
            errors++;
            $error("FAIL %s_ovf: ovf got %b expected %b", tag, ovf, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("note: %s", tag);
`endif
    endtask

    // Drive one vector away from the edge, let it be captured, then check just after the edge.
    task automatic apply(input string tag, input logic tr, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input logic tc, input logic te);
        @(negedge clk);
        rst = tr; a = ta; b = tb_v; cin = tc; en = te;
        @(posedge clk);
        #1;
        if (tr) check(tag, '0, 1'b0);
        else    check(tag, model_sum(ta, tb_v, tc, te), model_ovf(ta, tb_v, tc, te));
    endtask

    initial begin
        apply("reset0", 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
        apply("reset1", 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0; a = 4'b1000; b = 4'b0001; cin = 1'b0; en = 1'b0;
        #1;
        check("hold_after_rst", '0, 1'b0);
        @(posedge clk);
        #1;
        check("add_8_1", 5'b0_1001, 1'b0);
        apply("add_2_6",      1'b0, 4'b0010, 4'b0110, 1'b0, 1'b0);
        apply("sub_12_10",    1'b0, 4'b1100, 4'b1010, 1'b1, 1'b1);
        apply("sub_8_1",      1'b0, 4'b1000, 4'b0001, 1'b1, 1'b1);
        apply("sub_8_9",      1'b0, 4'b1000, 4'b1001, 1'b1, 1'b1);
        apply("sub_10_12",    1'b0, 4'b1010, 4'b1100, 1'b1, 1'b1);
        apply("add_wrap",     1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0);
        apply("sub_nocin",    1'b0, 4'b0101, 4'b0011, 1'b0, 1'b1);
        apply("sub_equal",    1'b0, 4'b0111, 4'b0111, 1'b1, 1'b1);
        apply("add_max",      1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         re;
            logic         rc;
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            re = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 3) == 0) ? ~re : re;
            apply($sformatf("rand%0d", i), i == 8, ra, rb, rc, re);
        end
        apply("post_rand", 1'b0, 4'b0011, 4'b0100, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/binary_adder_subtractor.md
# binary_adder_subtractor

Registered ripple-carry binary adder/subtractor, WIDTH bits wide (default 4). A mode input `en` selects the operation: add (`en`=0) or subtract (`en`=1), using two's-complement inversion of operand `b`. The block is a small datapath leaf used wherever a clocked add/subtract of two unsigned or two's-complement operands is needed. It has a one-cycle registered result.

## Interface
- WIDTH, 4, operand and result width in bits; legal values are ≥1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0. For a true subtract, the system ties or drives `cin` equal to `en`.
- en  input  1  mode select: 0 = add, 1 = subtract (invert `b`).
- s  output  WIDTH  registered sum/difference.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed overflow. Present only with ADDSUB_OVERFLOW_EN.

## Operation
- Effective operand: bx = b XOR {WIDTH{en}}.
- Combinational result: {cout_n, s_n} = a + bx + cin. This is a (WIDTH+1)-bit sum with no truncation of the carry.
- Structure: a chain of WIDTH full-adder cells. Each cell computes sum = x^y^c and carry = x&y | c&(x^y). c0 = cin. cout_n is the carry out of cell WIDTH-1.
- `cin` is independent of `en`:
  - en=0, cin=1 gives a+b+1.
  - en=1, cin=0 gives a+~b, i.e. a−b−1.
- Subtract semantics, with en=1 and cin=1:
  - s = (a−b) mod 2^WIDTH.
  - cout=1 means no borrow (a ≥ b, unsigned).
  - cout=0 means borrow.
- Signed overflow, when configured: ovf_n = carry into MSB XOR carry out of MSB.
- No internal state other than the output registers. There is no handshake: every clock captures a new result.

## Timing
- On the rising edge of clk:
  - if rst=1: s←0, cout←0, ovf←0.
  - else: s←s_n, cout←cout_n, ovf←ovf_n.
- Latency is 1 cycle. Inputs sampled at edge k appear on the outputs after edge k and hold until edge k+1.
- Throughput is one operation per cycle. Inputs may change every cycle.
- Reset has priority over capture. Asserting rst mid-stream discards the operation sampled at that edge. The first valid result appears on the edge after rst deasserts.
- Outputs are X-free after the first reset edge. Before any reset, output values are undefined.
- The combinational path a/b/en/cin → register is a full WIDTH-bit ripple and must meet the clk period.

## Configuration
- ADDSUB_OVERFLOW_EN:
  - Defined: port `ovf` exists and is registered as above.
  - Undefined: port `ovf` and its logic are absent. s and cout are unchanged.

## Test plan
- Reset: rst=1 for 2 cycles with a=1111, b=1111, cin=1 → s=0000, cout=0 (ovf=0); outputs stay 0 until the edge after rst drops.
- Add, en=0, cin=0:
  - a=1000, b=0001 → s=1001, cout=0 one cycle later.
  - a=0010, b=0110 → s=1000, cout=0 (ovf=1, since 2+6 overflows signed 4-bit).
- Subtract without borrow, en=1, cin=1:
  - a=1100, b=1010 → s=0010, cout=1.
  - a=1000, b=0001 → s=0111, cout=1 (ovf=1, since −8−1).
- Subtract with borrow, en=1, cin=1:
  - a=1000, b=1001 → s=1111, cout=0.
  - a=1010, b=1100 → s=1110, cout=0 (ovf=0).
- Carry-in and wrap, en=0:
  - a=1111, b=0000, cin=1 → s=0000, cout=1.
  - en=1, cin=0, a=0101, b=0011 → s=0001, cout=1.
- Back-to-back: change a/b/en every cycle for 16 random vectors, with rst pulsed once mid-stream. Each output must match the golden {cout,s} = a + (b^{4{en}}) + cin from the prior edge. The cycle after the rst edge must read 0.
